eth_clk_freq_meter: RTL and testbench

//  Memory-mapped edge-rate meter for the PHY clock-out pin (ETH_CLKOUT) and similar slow strobes.

---
 rtl/eth_clk_freq_meter_pkg.sv | 37 +++
 rtl/eth_clk_freq_meter_if.sv | 20 ++
 rtl/eth_sync_edge.sv | 32 +++
 rtl/eth_clk_freq_meter.sv | 154 +++++++++++++++
 tb/tb_eth_clk_freq_meter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_clk_freq_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_clk_freq_meter_pkg : register map, bit indices and FSM encoding         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package eth_clk_freq_meter_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int GATE_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_GATE   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_RESULT = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A zero gate still yields a one-cycle window.
  function automatic logic [GATE_W-1:0] gate_load(input logic [GATE_W-1:0] g);
    return (g == GATE_W'(0)) ? GATE_W'(1) : g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_clk_freq_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_clk_freq_meter_if : slave register bus between CPU and meter            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface eth_clk_freq_meter_if;
  import eth_clk_freq_meter_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/eth_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_sync_edge : two-flop synchroniser with one-cycle rising-edge pulse      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module eth_sync_edge (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/eth_clk_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_clk_freq_meter : counts synchronised rising edges over a gate window    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module eth_clk_freq_meter
  import eth_clk_freq_meter_pkg::*;
#(
  parameter int GATE_DEFAULT = 50_000_000,
  parameter int CNT_W        = 32
) (
  input  wire logic           clk,
  input  wire logic           reset,
  eth_clk_freq_meter_if.slave bus,
  input  wire logic           in_port,
  output logic                irq
);

  logic              w_edge;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_gate;
  logic              w_wr_stat;
  logic              w_run_now;
  logic              w_last;
  logic              w_sat;
  logic              w_load;
  logic              w_finish;
  logic              w_clr_run;
  logic [CNT_W-1:0]  w_edge_nxt;
  logic [DATA_W-1:0] w_rdata;
  state_t            w_state_nxt;

  state_t            r_state;
  logic [2:0]        r_ctrl;
  logic [GATE_W-1:0] r_gate;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  r_result;
  logic              r_done;
  logic              r_ovf;
  logic              r_ovf_pend;
  logic [DATA_W-1:0] r_readdata;

  eth_sync_edge u_sync (
    .clk    (clk),
    .rst    (reset),
    .i_d    (in_port),
    .o_rise (w_edge)
  );

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_wr_ctrl = w_wr && (bus.address == ADDR_CTRL);
  assign w_wr_gate = w_wr && (bus.address == ADDR_GATE);
  assign w_wr_stat = w_wr && (bus.address == ADDR_STATUS);
  // An abort must take effect in the same cycle the CPU clears run.
  assign w_run_now = w_wr_ctrl ? bus.writedata[CTRL_RUN] : r_ctrl[CTRL_RUN];
  assign w_last    = (r_gate_cnt == GATE_W'(1));
  assign w_sat     = w_edge & (&r_edge_cnt);
  assign w_edge_nxt = (w_edge && !(&r_edge_cnt)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    w_clr_run   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[CTRL_RUN]) begin
          w_state_nxt = ST_COUNT;
          w_load      = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!w_run_now) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end
      end
      ST_DONE: begin
        if (r_ctrl[CTRL_CONT] && w_run_now) begin
          w_state_nxt = ST_COUNT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_clr_run   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_CTRL:   w_rdata[2:0] = r_ctrl;
      ADDR_GATE:   w_rdata      = DATA_W'(r_gate);
      ADDR_RESULT: w_rdata      = DATA_W'(r_result);
      ADDR_STATUS: begin
        w_rdata[STAT_BUSY] = (r_state != ST_IDLE);
        w_rdata[STAT_DONE] = r_done;
        w_rdata[STAT_OVF]  = r_ovf;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_gate     <= GATE_W'(GATE_DEFAULT);
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_readdata <= w_rdata;
      if (w_wr_ctrl) r_ctrl <= bus.writedata[2:0];
      if (w_clr_run) r_ctrl[CTRL_RUN] <= 1'b0;
      if (w_wr_gate) r_gate <= bus.writedata[GATE_W-1:0];
      if (w_load) begin
        r_gate_cnt <= gate_load(r_gate);
        r_edge_cnt <= '0;
        r_ovf_pend <= 1'b0;
      end else if (r_state == ST_COUNT) begin
        r_gate_cnt <= r_gate_cnt - GATE_W'(1);
        r_edge_cnt <= w_edge_nxt;
        if (w_sat) r_ovf_pend <= 1'b1;
      end
      if (w_wr_stat) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end
      // Completion is ordered after the clear so a coincident STATUS write loses.
      if (w_finish) begin
        r_result <= w_edge_nxt;
        r_ovf    <= r_ovf_pend | w_sat;
        r_done   <= 1'b1;
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_done & r_ctrl[CTRL_IRQ_EN];

endmodule
`default_nettype wire

// File: tb/tb_eth_clk_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_clk_freq_meter : scoreboard bench, 32-bit and 4-bit counter builds   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_eth_clk_freq_meter;
  import eth_clk_freq_meter_pkg::*;

  localparam int GDEF = 50_000_000;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        in_port = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs      = 1'b0;
  logic        wn      = 1'b1;
  logic [31:0] wdata   = 32'd0;
  logic        irq_a;
  logic        irq_b;

  eth_clk_freq_meter_if bus_a ();
  eth_clk_freq_meter_if bus_b ();

  assign bus_a.address    = address;
  assign bus_a.chipselect = cs;
  assign bus_a.write_n    = wn;
  assign bus_a.writedata  = wdata;
  assign bus_b.address    = address;
  assign bus_b.chipselect = cs;
  assign bus_b.write_n    = wn;
  assign bus_b.writedata  = wdata;

  eth_clk_freq_meter #(.GATE_DEFAULT(GDEF), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_port), .irq(irq_a));
  eth_clk_freq_meter #(.GATE_DEFAULT(GDEF), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .in_port(in_port), .irq(irq_b));

  always #5 clk = ~clk;

  // Periodic stimulus: high for per/2 cycles, low for the rest; per=0 leaves in_port alone.
  int per = 0;
  int ph  = 0;
  always @(negedge clk) begin
    if (per > 0) begin
      in_port = (ph < per / 2);
      ph = (ph + 1) % per;
    end
  end

  typedef struct {
    string       name;
    bit          src_b;
    bit          is_irq;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   rd_req = 1'b0;
  bit   rd_vld = 1'b0;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      exp_t        e;
      logic [31:0] act;
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL orphan: read with no expectation queued");
      end else begin
        e = q.pop_front();
        if (e.is_irq) act = {31'd0, (e.src_b ? irq_b : irq_a)};
        else          act = e.src_b ? bus_b.readdata : bus_a.readdata;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic push(input string nm, input bit b, input bit is_irq, input logic [31:0] e);
    exp_t x;
    x.name = nm; x.src_b = b; x.is_irq = is_irq; x.exp = e;
    q.push_back(x);
  endtask

  task automatic rd(input logic [1:0] a, input bit b, input logic [31:0] e, input string nm);
    @(negedge clk);
    address = a;
    rd_req  = 1'b1;
    push(nm, b, 1'b0, e);
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic chk_irq(input bit b, input logic e, input string nm);
    @(negedge clk);
    rd_req = 1'b1;
    push(nm, b, 1'b1, {31'd0, e});
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; wdata = d; cs = 1'b1; wn = 1'b0;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    address = ADDR_STATUS;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.readdata[STAT_DONE] && n < budget);
    if (!bus_a.readdata[STAT_DONE]) begin
      n_chk++;
      $display("FAIL %s: done not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_irq(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!irq_a && n < budget);
    if (!irq_a) begin
      n_chk++;
      $display("FAIL %s: irq not seen within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values, including forced-zero readdata while reset is held.
    rd(ADDR_GATE, 1'b0, 32'd0, "rst_rdata");
    chk_irq(1'b0, 1'b0, "rst_irq");
    reset = 1'b0;
    rd(ADDR_GATE,   1'b0, GDEF, "rst_gate");
    rd(ADDR_STATUS, 1'b0, 32'd0, "rst_status");
    rd(ADDR_RESULT, 1'b0, 32'd0, "rst_result");
    rd(ADDR_CTRL,   1'b0, 32'd0, "rst_ctrl");

    // Single shot: 100-cycle window, period 10.
    ph = 0; per = 10;
    wr(ADDR_GATE, 32'd100);
    wr(ADDR_CTRL, 32'd1);
    rd(ADDR_STATUS, 1'b0, 32'd1, "ss_busy");
    wait_done(300, "ss_wait");
    rd(ADDR_RESULT, 1'b0, 32'd10, "ss_result");
    rd(ADDR_STATUS, 1'b0, 32'd2,  "ss_status");
    rd(ADDR_CTRL,   1'b0, 32'd0,  "ss_run_clr");

    // GATE=0: one-cycle window with an edge landing on it.
    per = 0; in_port = 1'b0;
    wr(ADDR_STATUS, 32'd0);
    wr(ADDR_GATE, 32'd0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    address = ADDR_CTRL; wdata = 32'd1; cs = 1'b1; wn = 1'b0; in_port = 1'b1;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1; in_port = 1'b0;
    wait_done(20, "g0_wait");
    rd(ADDR_RESULT, 1'b0, 32'd1, "g0_result");
    rd(ADDR_GATE,   1'b0, 32'd0, "g0_gate_raw");

    // GATE=5: single edge on the last gate cycle.
    wr(ADDR_STATUS, 32'd0);
    wr(ADDR_GATE, 32'd5);
    repeat (4) @(negedge clk);
    @(negedge clk);
    address = ADDR_CTRL; wdata = 32'd1; cs = 1'b1; wn = 1'b0;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1;
    repeat (3) @(negedge clk);
    in_port = 1'b1;
    @(negedge clk);
    in_port = 1'b0;
    wait_done(20, "g5_wait");
    rd(ADDR_RESULT, 1'b0, 32'd1, "g5_last_edge");

    // Continuous with irq: 50-cycle windows every 51 cycles, period 5.
    wr(ADDR_STATUS, 32'd0);
    ph = 0; per = 5;
    wr(ADDR_GATE, 32'd50);
    wr(ADDR_CTRL, 32'd7);
    wait_irq(200, "cont_wait1");
    rd(ADDR_RESULT, 1'b0, 32'd10, "cont_result1");
    chk_irq(1'b0, 1'b1, "cont_irq1");
    wr(ADDR_STATUS, 32'd0);
    chk_irq(1'b0, 1'b0, "cont_irq_clr");
    wait_irq(200, "cont_wait2");
    wr(ADDR_STATUS, 32'd0);
    repeat (47) @(negedge clk);
    wr(ADDR_STATUS, 32'd0);       // lands on the cycle the next window completes
    rd(ADDR_STATUS, 1'b0, 32'd3,  "cont_set_wins");
    rd(ADDR_RESULT, 1'b0, 32'd10, "cont_result2");
    chk_irq(1'b0, 1'b1, "cont_irq2");
    wr(ADDR_CTRL, 32'd0);

    // Saturation on the 4-bit build; the 32-bit build sees the true count.
    wr(ADDR_STATUS, 32'd0);
    ph = 0; per = 2;
    wr(ADDR_GATE, 32'd64);
    wr(ADDR_CTRL, 32'd1);
    wait_done(200, "ovf_wait");
    rd(ADDR_RESULT, 1'b1, 32'd15, "ovf_result");
    rd(ADDR_STATUS, 1'b1, 32'd6,  "ovf_status");
    rd(ADDR_RESULT, 1'b0, 32'd32, "wide_result");
    wr(ADDR_STATUS, 32'd0);
    rd(ADDR_STATUS, 1'b1, 32'd0,  "ovf_clr");

    // Abort mid-window keeps the previous result.
    ph = 0; per = 10;
    wr(ADDR_GATE, 32'd100);
    wr(ADDR_CTRL, 32'd1);
    repeat (20) @(negedge clk);
    wr(ADDR_CTRL, 32'd0);
    rd(ADDR_STATUS, 1'b0, 32'd0,  "abort_idle");
    rd(ADDR_RESULT, 1'b0, 32'd32, "abort_keep");

    // Reset mid-window.
    wr(ADDR_CTRL, 32'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    rd(ADDR_RESULT, 1'b0, 32'd0, "rstmid_rdata");
    reset = 1'b0;
    rd(ADDR_RESULT, 1'b0, 32'd0, "rstmid_result");
    rd(ADDR_STATUS, 1'b0, 32'd0, "rstmid_status");
    rd(ADDR_GATE,   1'b0, GDEF,  "rstmid_gate");
    rd(ADDR_CTRL,   1'b0, 32'd0, "rstmid_ctrl");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
